// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch plus the IF/ID pipeline register.
//
// Owns PC_F and keeps at most one request outstanding to instruction memory.
// A response that arrives while decode is stalled is parked in a one-entry
// buffer (HOLD). That frees the memory port and lets decode keep its IF/ID
// contents. An E-stage redirect (PCSrcE) moves PC_F to PCTargetE at once. If
// a request is still in flight at that moment, its late response is dropped
// through the kill flag.
//
// Optional build macro: FETCH_PERF_CNT_EN adds the FetchCnt/BubbleCnt counters.
//
// Ports:
//   clk, rst_n              core clock, async active-low reset
//   StallD, FlushD          decode hold / squash IF/ID
//   PCSrcE, PCTargetE       redirect from E stage
//   imem_req, imem_addr     fetch request (imem_addr == PC_F)
//   imem_rdata, imem_rvalid fetch response
//   Instr_D, PC_D, PCPlus4_D, Valid_D   IF/ID register toward decode
//   FetchBusy               request outstanding with no usable response
//   FetchCnt, BubbleCnt     (FETCH_PERF_CNT_EN only) valid loads / memory bubbles
module fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [ADDR_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  imem_rvalid,
  output logic [INST_WIDTH-1:0] Instr_D,
  output logic [ADDR_WIDTH-1:0] PC_D,
  output logic [ADDR_WIDTH-1:0] PCPlus4_D,
  output logic                  Valid_D,
  output logic                  FetchBusy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           FetchCnt,
  output logic [31:0]           BubbleCnt
`endif
);

  localparam logic [INST_WIDTH-1:0] NOP  = INST_WIDTH'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [INST_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pcplus4;
    logic                  valid;
  } ifid_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc_f, pc_n;
  logic                  kill, kill_n;
  logic [INST_WIDTH-1:0] buf_instr, buf_instr_n;
  logic [ADDR_WIDTH-1:0] buf_pc, buf_pc_n;
  ifid_t                 ifid, ifid_n, bubble;

  // Response that belongs to the current PC_F and may be consumed now.
  logic rsp_ok;
  assign rsp_ok = (state == WAIT) && imem_rvalid && !kill;

  always_comb begin
    state_n     = state;
    pc_n        = pc_f;
    kill_n      = kill;
    buf_instr_n = buf_instr;
    buf_pc_n    = buf_pc;
    ifid_n      = ifid;
    // A bubble keeps PC_D/PCPlus4_D and swaps in a NOP.
    bubble       = ifid;
    bubble.instr = NOP;
    bubble.valid = 1'b0;

    if (PCSrcE) begin
      pc_n    = PCTargetE;
      state_n = WAIT;
      ifid_n  = bubble;
      // kill is only ever set in WAIT. If a response shows up this same
      // cycle, it is the one being discarded, so no later drop is pending.
      kill_n  = (state == WAIT) && !imem_rvalid;
    end else begin
      unique case (state)
        WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill_n = 1'b0;               // stale response from before a redirect
            end else if (StallD) begin
              buf_instr_n = imem_rdata;
              buf_pc_n    = pc_f;
              state_n     = HOLD;
            end else begin
              pc_n = pc_f + FOUR;
            end
          end
        end
        HOLD: begin
          if (!StallD) begin
            pc_n    = buf_pc + FOUR;
            state_n = WAIT;
          end
        end
        default: state_n = WAIT;           // IDLE: one settling cycle after reset
      endcase

      // IF/ID update: flush beats stall, stall holds, otherwise load the new
      // instruction or a bubble. Nothing is loaded in IDLE: the register
      // already holds the reset bubble.
      if (FlushD) begin
        ifid_n = bubble;
      end else if (!StallD) begin
        if (rsp_ok) begin
          ifid_n = '{instr: imem_rdata, pc: pc_f, pcplus4: pc_f + FOUR, valid: 1'b1};
        end else if (state == HOLD) begin
          ifid_n = '{instr: buf_instr, pc: buf_pc, pcplus4: buf_pc + FOUR, valid: 1'b1};
        end else if (state == WAIT) begin
          ifid_n = bubble;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_f      <= RESET_PC;
      kill      <= 1'b0;
      buf_instr <= NOP;
      buf_pc    <= '0;
      ifid      <= '{instr: NOP, pc: '0, pcplus4: '0, valid: 1'b0};
    end else begin
      state     <= state_n;
      pc_f      <= pc_n;
      kill      <= kill_n;
      buf_instr <= buf_instr_n;
      buf_pc    <= buf_pc_n;
      ifid      <= ifid_n;
    end
  end

  assign imem_req  = (state == WAIT);
  assign imem_addr = pc_f;
  assign FetchBusy = (state == WAIT) && (!imem_rvalid || kill);
  assign Instr_D   = ifid.instr;
  assign PC_D      = ifid.pc;
  assign PCPlus4_D = ifid.pcplus4;
  assign Valid_D   = ifid.valid;

`ifdef FETCH_PERF_CNT_EN
  logic ld_free, fetch_inc, bubble_inc;
  // IF/ID takes fresh contents this cycle (no redirect, flush or stall).
  assign ld_free    = !PCSrcE && !FlushD && !StallD;
  assign fetch_inc  = ld_free && (rsp_ok || (state == HOLD));
  assign bubble_inc = ld_free && (state == WAIT) && !imem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FetchCnt  <= '0;
      BubbleCnt <= '0;
    end else begin
      if (fetch_inc)  FetchCnt  <= FetchCnt + 32'd1;
      if (bubble_inc) BubbleCnt <= BubbleCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. The stimulus process queues the
// instructions expected in IF/ID, in order. A monitor pops and compares
// whenever IF/ID takes a new valid instruction. A behavioural memory answers
// each request a programmable number of cycles later.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk, rst_n;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] Instr_D, PC_D, PCPlus4_D;
  logic        Valid_D, FetchBusy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCnt, BubbleCnt;
`endif

  fetch_stage #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .Instr_D(Instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .Valid_D(Valid_D), .FetchBusy(FetchBusy)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCnt(FetchCnt), .BubbleCnt(BubbleCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h00F0_0193;
      32'h0000_000C: return 32'h0140_0213;
      32'h0000_0010: return 32'hDEAD_BEEF;
      32'h0000_0100: return 32'h0000_A0B7;
      32'h0000_0104: return 32'hBAD0_0104;
      32'h0000_0200: return 32'h1234_5678;
      32'h0000_0204: return 32'hBAD0_0204;
      32'hFFFF_FFFC: return 32'h0010_0073;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc; e.instr = instr;
    sb.push_back(e);
  endtask

  // Memory: takes a request at a falling edge, raises rvalid lat falling
  // edges later for one cycle, and accepts nothing while one is pending.
  int          lat = 1;
  int          mem_cnt = 0;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_busy = 1'b0; imem_rvalid = 1'b0;
      end else begin
        if (imem_rvalid) begin
          imem_rvalid = 1'b0; mem_busy = 1'b0;
        end else if (mem_busy) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            imem_rvalid = 1'b1; imem_rdata = mem_word(mem_addr);
          end
        end
        if (!mem_busy && imem_req) begin
          mem_busy = 1'b1; mem_addr = imem_addr; mem_cnt = lat;
        end
      end
    end
  end

  // Monitor: IF/ID takes new contents on every edge where StallD was low.
  logic stall_q = 1'b0;
  initial forever begin
    @(posedge clk);
    stall_q = StallD;
  end
  initial forever begin
    @(negedge clk);
    if (rst_n && Valid_D && !stall_q) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_instr: got pc %h instr %h, expected none", PC_D, Instr_D);
      end else begin
        exp_t e;
        logic [31:0] p4;
        e  = sb.pop_front();
        p4 = e.pc + 32'd4;
        chk("sb_instr", Instr_D, e.instr);
        chk("sb_pc", PC_D, e.pc);
        chk("sb_pcplus4", PCPlus4_D, p4);
      end
    end
  end

  localparam int C_RV8 = 0, C_REQ10 = 1, C_RV10 = 2, C_RV104 = 3, C_VD200 = 4,
                 C_REQ204 = 5, C_VDWRAP = 6, C_QEMPTY = 7;

  function automatic bit cond(input int id);
    case (id)
      C_RV8:    return imem_rvalid && mem_addr == 32'h8;
      C_REQ10:  return imem_req && imem_addr == 32'h10 && mem_busy && !imem_rvalid;
      C_RV10:   return imem_rvalid && mem_addr == 32'h10;
      C_RV104:  return imem_rvalid && mem_addr == 32'h104;
      C_VD200:  return Valid_D && PC_D == 32'h200;
      C_REQ204: return imem_req && imem_addr == 32'h204 && !imem_rvalid;
      C_VDWRAP: return Valid_D && PC_D == 32'hFFFF_FFFC;
      default:  return sb.size() == 0;
    endcase
  endfunction

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_cond(input int id, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (cond(id)) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL timeout_%s: not seen, expected within 300 cycles", name);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_imem_req"},  {31'b0, imem_req},  32'h0);
    chk({tag, "_imem_addr"}, imem_addr,          RST_PC);
    chk({tag, "_instr"},     Instr_D,            NOP);
    chk({tag, "_pc_d"},      PC_D,               32'h0);
    chk({tag, "_pcplus4"},   PCPlus4_D,          32'h0);
    chk({tag, "_valid"},     {31'b0, Valid_D},   32'h0);
    chk({tag, "_busy"},      {31'b0, FetchBusy}, 32'h0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    // Complete expected IF/ID stream: 0x10, 0x104 and 0x204 are squashed.
    push(32'h0000_0000, 32'h0050_0093);
    push(32'h0000_0004, 32'h00A0_0113);
    push(32'h0000_0008, 32'h00F0_0193);
    push(32'h0000_000C, 32'h0140_0213);
    push(32'h0000_0100, 32'h0000_A0B7);
    push(32'h0000_0200, 32'h1234_5678);
    push(32'hFFFF_FFFC, 32'h0010_0073);
    push(32'h0000_0000, 32'h0050_0093);   // after the mid-fetch reset
    push(32'h0000_0004, 32'h00A0_0113);

    step(); step();
    chk_reset("reset");
    rst_n = 1'b1;
    step();
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, RST_PC);

    // Decode stall when the response for 0x8 arrives: park it in HOLD.
    wait_cond(C_RV8, "rv8");
    StallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_req", {31'b0, imem_req}, 32'h0);
      chk("hold_valid", {31'b0, Valid_D}, 32'h0);
      chk("hold_pc_d", PC_D, 32'h4);
      chk("hold_busy", {31'b0, FetchBusy}, 32'h0);
    end
    StallD = 1'b0;
    lat = 2;
    step();
    chk("release_pc_d", PC_D, 32'h8);
    chk("release_addr", imem_addr, 32'hC);
    chk("release_req", {31'b0, imem_req}, 32'h1);

    // Two-cycle memory: FetchBusy for two cycles, bubble in IF/ID meanwhile.
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (FetchBusy) n++;
      if (imem_rvalid) break;
      step();
    end
    chk("busy_cycles", n, 32'd2);
    chk("gap_valid", {31'b0, Valid_D}, 32'h0);
    chk("gap_instr", Instr_D, NOP);
    lat = 3;

    // Redirect while 0x10 is outstanding: its late response must be dropped.
    wait_cond(C_REQ10, "req10");
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    step();
    PCSrcE = 1'b0;
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid", {31'b0, Valid_D}, 32'h0);
    wait_cond(C_RV10, "rv10");
    chk("kill_busy", {31'b0, FetchBusy}, 32'h1);
    step();
    chk("kill_drop_valid", {31'b0, Valid_D}, 32'h0);
    chk("kill_addr", imem_addr, 32'h100);

    // Redirect in the same cycle as the 0x104 response.
    wait_cond(C_RV104, "rv104");
    PCSrcE = 1'b1; PCTargetE = 32'h200;
    step();
    PCSrcE = 1'b0;
    chk("same_cyc_addr", imem_addr, 32'h200);
    chk("same_cyc_mem_addr", mem_addr, 32'h200);
    chk("same_cyc_valid", {31'b0, Valid_D}, 32'h0);

    // Flush and stall together: flush wins.
    wait_cond(C_VD200, "vd200");
    FlushD = 1'b1; StallD = 1'b1;
    step();
    FlushD = 1'b0; StallD = 1'b0;
    chk("flush_valid", {31'b0, Valid_D}, 32'h0);
    chk("flush_instr", Instr_D, NOP);
    chk("flush_pc_d", PC_D, 32'h200);
    chk("flush_pcplus4", PCPlus4_D, 32'h204);

    // Redirect to the last word: PC+4 wraps to 0.
    wait_cond(C_REQ204, "req204");
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    step();
    PCSrcE = 1'b0;
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    wait_cond(C_VDWRAP, "vdwrap");
    chk("wrap_pcplus4", PCPlus4_D, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_next_req", {31'b0, imem_req}, 32'h1);

    // Reset mid-WAIT: outputs clear without waiting for a clock edge.
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    step(); step();
    rst_n = 1'b1;
    step();
    chk("restart_req", {31'b0, imem_req}, 32'h1);
    chk("restart_addr", imem_addr, RST_PC);
    wait_cond(C_QEMPTY, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end
endmodule
